// File: rtl/i2c_sync_fifo_pkg.sv
// i2c_sync_fifo_pkg: status bit indices and default FIFO geometry shared by the I2C FIFOs.
package i2c_sync_fifo_pkg;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_AEMPTY    = 2;
  localparam int ST_AFULL     = 3;
  localparam int ST_OVERFLOW  = 4;
  localparam int ST_UNDERFLOW = 5;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_AF_LEVEL   = 14;
  localparam int FIFO_AE_LEVEL   = 2;
endpackage

// File: rtl/i2c_fifo_mem.sv
// i2c_fifo_mem: FIFO storage array, synchronous write and asynchronous read.
module i2c_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  pclk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge pclk_i) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock byte FIFO with registered flags and read data.
// Define I2C_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until clr_i or reset.
module i2c_sync_fifo
  import i2c_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = FIFO_AF_LEVEL,
  parameter int AE_LEVEL   = FIFO_AE_LEVEL
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  clr_i,
  input  logic                  winc_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rinc_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [7:0]            status_o
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH:0] wptr, rptr, wptr_d, rptr_d, count_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
  logic push, pop, ovf_ev, unf_ev, ovf_d, unf_d, full_d;
  // A pop on a full FIFO frees the slot, so a simultaneous push is still taken.
  assign push    = !clr_i && winc_i && (!full_q || rinc_i);
  assign pop     = !clr_i && rinc_i && !empty_q;
  assign ovf_ev  = !clr_i && winc_i && full_q && !rinc_i;
  assign unf_ev  = !clr_i && rinc_i && empty_q;
  assign wptr_d  = clr_i ? '0 : wptr + PW'(push);
  assign rptr_d  = clr_i ? '0 : rptr + PW'(pop);
  assign count_d = wptr_d - rptr_d;
  assign full_d  = (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                   (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
`ifdef I2C_FIFO_STICKY_ERR_EN
  assign ovf_d = !clr_i && (ovf_q || ovf_ev);
  assign unf_d = !clr_i && (unf_q || unf_ev);
`else
  assign ovf_d = ovf_ev;
  assign unf_d = unf_ev;
`endif
  i2c_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .pclk_i(pclk_i),
    .we    (push),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata_i),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      wptr    <= '0;
      rptr    <= '0;
      rdata_o <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr    <= wptr_d;
      rptr    <= rptr_d;
      rdata_o <= pop ? mem_rdata : rdata_o;
      empty_q <= wptr_d == rptr_d;
      full_q  <= full_d;
      ae_q    <= count_d <= PW'(AE_LEVEL);
      af_q    <= count_d >= PW'(AF_LEVEL);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign count_o = wptr - rptr;
  always_comb begin
    status_o               = '0;
    status_o[ST_EMPTY]     = empty_q;
    status_o[ST_FULL]      = full_q;
    status_o[ST_AEMPTY]    = ae_q;
    status_o[ST_AFULL]     = af_q;
    status_o[ST_OVERFLOW]  = ovf_q;
    status_o[ST_UNDERFLOW] = unf_q;
  end
endmodule

// File: tb/tb_i2c_sync_fifo.sv
// tb_i2c_sync_fifo: directed checks of i2c_sync_fifo; follows I2C_FIFO_STICKY_ERR_EN if defined.
module tb_i2c_sync_fifo;
  logic       pclk_i = 1'b0;
  logic       preset_ni = 1'b0;
  logic       clr_i = 1'b0, winc_i = 1'b0, rinc_i = 1'b0;
  logic [7:0] wdata_i = '0;
  logic [7:0] rdata_o;
  logic [4:0] count_o;
  logic [7:0] status_o;
  int total = 0, bad = 0;
`ifdef I2C_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  i2c_sync_fifo dut (
    .pclk_i(pclk_i), .preset_ni(preset_ni), .clr_i(clr_i), .winc_i(winc_i),
    .wdata_i(wdata_i), .rinc_i(rinc_i), .rdata_o(rdata_o), .count_o(count_o),
    .status_o(status_o)
  );
  always #5 pclk_i = ~pclk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Called at a falling edge: drive inputs across one rising edge, return at the next falling edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    winc_i = w; wdata_i = d; rinc_i = r; clr_i = c;
    @(negedge pclk_i);
    winc_i = 1'b0; rinc_i = 1'b0; clr_i = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_status", status_o, 8'h05);
    check("rst_count", count_o, 0);
    check("rst_rdata", rdata_o, 0);
    @(negedge pclk_i);
    preset_ni = 1'b1;
    cyc(0, 0, 0, 0);
    check("idle_status", status_o, 8'h05);
    cyc(1, 8'hA5, 0, 0);
    check("t2_count", count_o, 1);
    check("t2_status", status_o, 8'h04);
    cyc(0, 0, 1, 0);
    check("t2_rdata", rdata_o, 8'hA5);
    check("t2_status_pop", status_o, 8'h05);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 12) check("t3_status13", status_o, 8'h00);
      if (i == 13) check("t3_status14", status_o, 8'h08);
    end
    check("t3_count16", count_o, 16);
    check("t3_status16", status_o, 8'h0A);
    cyc(1, 8'hFF, 0, 0);
    check("t3_ovf_status", status_o, 8'h1A);
    check("t3_ovf_count", count_o, 16);
    cyc(0, 0, 0, 0);
    check("t3_ovf_after", status_o, STICKY ? 8'h1A : 8'h0A);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("t3_pop", rdata_o, i);
    end
    check("t3_empty", status_o, STICKY ? 8'h15 : 8'h05);
    cyc(0, 0, 0, 1);
    check("t3_clr", status_o, 8'h05);
    for (int i = 0; i < 16; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    check("t4_rdata", rdata_o, 8'h10);
    check("t4_count", count_o, 16);
    check("t4_status", status_o, 8'h0A);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("t4_pop", rdata_o, 8'h10 + i);
    end
    cyc(0, 0, 1, 0);
    check("t4_last", rdata_o, 8'h55);
    check("t4_empty", status_o, 8'h05);
    cyc(1, 8'h3C, 1, 0);
    check("t5_status", status_o, 8'h24);
    check("t5_count", count_o, 1);
    check("t5_rdata", rdata_o, 8'h55);
    cyc(0, 0, 0, 0);
    check("t5_unf_after", status_o, STICKY ? 8'h24 : 8'h04);
    cyc(0, 0, 1, 0);
    check("t5_pop", rdata_o, 8'h3C);
    cyc(0, 0, 0, 1);
    check("t5_clr", status_o, 8'h05);
    cyc(1, 8'h80, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'h81 + 8'(i), 1, 0);
      check("t6_wrap", rdata_o, 8'h80 + i);
    end
    check("t6_count1", count_o, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'hE0 + 8'(i), 0, 0);
    check("t6_count5", count_o, 5);
    check("t6_status5", status_o, 8'h00);
    cyc(1, 8'hEE, 1, 1);
    check("t6_clr_status", status_o, 8'h05);
    check("t6_clr_count", count_o, 0);
    check("t6_clr_rdata", rdata_o, 8'hA7);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(0, 0, 1, 0);
    check("t6_after_clr", rdata_o, 8'h11);
    #2 preset_ni = 1'b0;
    #1;
    check("arst_count", count_o, 0);
    check("arst_rdata", rdata_o, 0);
    check("arst_status", status_o, 8'h05);
    @(negedge pclk_i);
    preset_ni = 1'b1;
    cyc(1, 8'h77, 0, 0);
    cyc(0, 0, 1, 0);
    check("arst_reuse", rdata_o, 8'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
